// File: rtl/trace_uart_pkg.sv
// Shared types and framing helpers for the trace/console UART arbiter.
// A trace word goes out as a 5-byte frame: header nibble plus the top data nibble, then four data bytes.
package trace_uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CON  = 2'd1,
    TRC  = 2'd2
  } state_t;

  typedef enum logic {
    GNT_TRACE = 1'b0,
    GNT_CON   = 1'b1
  } grant_t;

  localparam int         FRAME_BYTES = 5;
  localparam logic [3:0] TRACE_HDR   = 4'hA;

  function automatic logic [7:0] frame_byte(input logic [35:0] word, input logic [2:0] idx);
    case (idx)
      3'd0:    return {TRACE_HDR, word[35:32]};
      3'd1:    return word[31:24];
      3'd2:    return word[23:16];
      3'd3:    return word[15:8];
      default: return word[7:0];
    endcase
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Single-clock synchronous FIFO holding captured trace words.
// Pushes are ignored when full and pops are ignored when empty, so callers only need to qualify intent.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 36
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == FULL_LVL);
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Depth is a power of two, so pointer wrap is the natural overflow of AW bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/trace_uart_arbiter.sv
// Shares one UART transmitter between console bytes and captured CPU trace words.
// Trace capture stops at the first trap; whole frames and single console bytes alternate round robin.
module trace_uart_arbiter
  import trace_uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int OVF_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [35:0]                   trace_data,
  input  logic                          trace_valid,
  input  logic                          trap,
  input  logic [7:0]                    con_data,
  input  logic                          con_valid,
  output logic                          con_ready,
  output logic [7:0]                    tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [OVF_WIDTH-1:0]          overflow_count,
  output logic                          done
);

  localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);

  state_t      state;
  grant_t      last_grant;
  logic        trap_seen;
  logic [35:0] shift_word;
  logic [2:0]  byte_idx;

  logic        fifo_full;
  logic        fifo_empty;
  logic [35:0] fifo_word;
  logic        capture;
  logic        push;
  logic        drop;
  logic        grant_con;
  logic        grant_trc;

  // trap_seen is the registered flag, so the word arriving with the first trap is still taken.
  assign capture = trace_valid && !trap_seen;
  assign push    = capture && !fifo_full;
  assign drop    = capture && fifo_full;

  trace_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (36)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (trace_data),
    .pop       (grant_trc),
    .pop_data  (fifo_word),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      trap_seen      <= 1'b0;
      overflow_count <= '0;
    end else begin
      if (trap) trap_seen <= 1'b1;
      if (drop && (overflow_count != '1)) overflow_count <= overflow_count + OVF_WIDTH'(1);
    end
  end

  always_comb begin
    grant_con = 1'b0;
    grant_trc = 1'b0;
    if (state == IDLE) begin
      if (con_valid && (fifo_empty || (last_grant == GNT_TRACE))) grant_con = 1'b1;
      else if (!fifo_empty)                                       grant_trc = 1'b1;
    end
  end

  assign con_ready = grant_con;
  assign done      = trap_seen && fifo_empty && (state == IDLE) && !tx_valid;

  // Every exit to IDLE drops tx_valid, which guarantees the idle gap between grants.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= GNT_TRACE;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      shift_word <= '0;
      byte_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_con) begin
            tx_data    <= con_data;
            tx_valid   <= 1'b1;
            last_grant <= GNT_CON;
            state      <= CON;
          end else if (grant_trc) begin
            tx_data    <= frame_byte(fifo_word, 3'd0);
            tx_valid   <= 1'b1;
            shift_word <= fifo_word;
            byte_idx   <= '0;
            last_grant <= GNT_TRACE;
            state      <= TRC;
          end
        end
        CON: begin
          if (tx_valid && tx_ready) begin
            tx_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        TRC: begin
          if (tx_valid && tx_ready) begin
            if (byte_idx == LAST_IDX) begin
              tx_valid <= 1'b0;
              state    <= IDLE;
            end else begin
              byte_idx <= byte_idx + 3'd1;
              tx_data  <= frame_byte(shift_word, byte_idx + 3'd1);
            end
          end
        end
        default: begin
          tx_valid <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trace_uart_arbiter.sv
// Directed bench for trace_uart_arbiter: expected UART bytes are queued at stimulus time
// and a negedge monitor pops and compares them on every tx handshake.
module tb_trace_uart_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [35:0] trace_data = '0;
  logic        trace_valid = 1'b0;
  logic        trap = 1'b0;
  logic [7:0]  con_data = '0;
  logic        con_valid = 1'b0;
  logic        con_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [4:0]  fifo_level;
  logic [15:0] overflow_count;
  logic        done;

  trace_uart_arbiter #(.FIFO_DEPTH(16), .OVF_WIDTH(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .trace_data     (trace_data),
    .trace_valid    (trace_valid),
    .trap           (trap),
    .con_data       (con_data),
    .con_valid      (con_valid),
    .con_ready      (con_ready),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .fifo_level     (fifo_level),
    .overflow_count (overflow_count),
    .done           (done)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pop on handshake, plus tx_data stability while stalled.
  logic       hold_prev = 1'b0;
  logic [7:0] data_prev = '0;
  always @(negedge clk) begin
    if (!reset && tx_valid && hold_prev) check("tx_data_stable", tx_data, data_prev);
    hold_prev = !reset && tx_valid && !tx_ready;
    data_prev = tx_data;
    if (!reset && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL tx_byte: actual %0h required none (no byte expected)", tx_data);
      end else begin
        check("tx_byte", tx_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    trace_valid = 1'b0;
    con_valid = 1'b0;
    trap = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic exp_word(input logic [35:0] w);
    exp_q.push_back({4'hA, w[35:32]});
    exp_q.push_back(w[31:24]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  task automatic send_con(input logic [7:0] b, output int waited, output logic gap_idle);
    logic got;
    got = 1'b0;
    waited = 0;
    gap_idle = 1'b0;
    con_valid = 1'b1;
    con_data = b;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (con_ready) begin
        got = 1'b1;
        gap_idle = !tx_valid;
      end else begin
        waited++;
      end
    end
    check("con_granted", got, 1'b1);
    tick();
    con_valid = 1'b0;
  endtask

  task automatic drain(input int max, input string name);
    for (int i = 0; i < max; i++) begin
      if (exp_q.size() == 0 && !tx_valid) break;
      tick();
    end
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_tx_idle"}, tx_valid, 1'b0);
  endtask

  int          waited;
  logic        gap;
  logic [35:0] w;

  initial begin
    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_level", fifo_level, 5'd0);
    check("rst_ovf", overflow_count, 16'd0);
    check("rst_done", done, 1'b0);
    check("rst_con_ready", con_ready, 1'b0);
    tick();

    // Single trace word, continuous tx_ready
    tx_ready = 1'b1;
    exp_q.push_back(8'hA9);
    exp_q.push_back(8'hDE);
    exp_q.push_back(8'hAD);
    exp_q.push_back(8'hBE);
    exp_q.push_back(8'hEF);
    trace_data = 36'h9_DEAD_BEEF;
    trace_valid = 1'b1;
    tick();
    trace_valid = 1'b0;
    @(negedge clk);
    check("t1_latency_gap", tx_valid, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t1_contiguous", tx_valid, 1'b1);
    end
    @(negedge clk);
    check("t1_end", tx_valid, 1'b0);
    check("t1_queue", exp_q.size(), 0);
    check("t1_no_done", done, 1'b0);
    tick();

    // Full FIFO and overflow: a stalled console byte keeps the FSM from popping
    do_reset();
    tx_ready = 1'b0;
    exp_q.push_back(8'h55);
    send_con(8'h55, waited, gap);
    for (int i = 0; i < 17; i++) begin
      w = {4'(i), 32'hC0DE_0000 + 32'(i)};
      if (i < 16) exp_word(w);
      trace_data = w;
      trace_valid = 1'b1;
      tick();
    end
    trace_valid = 1'b0;
    check("t2_level_full", fifo_level, 5'd16);
    check("t2_overflow", overflow_count, 16'd1);
    tx_ready = 1'b1;
    drain(400, "t2");
    check("t2_level_empty", fifo_level, 5'd0);

    // Tie after reset goes to console, and the next tie does too
    do_reset();
    tx_ready = 1'b1;
    exp_q.push_back(8'h41);
    exp_word(36'h1_1234_5678);
    exp_q.push_back(8'h42);
    exp_word(36'h2_0BAD_F00D);
    trace_data = 36'h1_1234_5678;
    trace_valid = 1'b1;
    tick();
    trace_valid = 1'b0;
    send_con(8'h41, waited, gap);
    check("t3_con_first_wait", waited, 0);
    check("t3_word_kept", fifo_level, 5'd1);
    tick();
    tick();
    trace_data = 36'h2_0BAD_F00D;
    trace_valid = 1'b1;
    tick();
    trace_valid = 1'b0;
    send_con(8'h42, waited, gap);
    check("t3_second_tie_wait", waited, 4);
    check("t3_second_tie_gap", gap, 1'b1);
    check("t3_second_tie_kept", fifo_level, 5'd1);
    drain(100, "t3");

    // Console request during byte 2 waits for frame end plus one idle cycle
    do_reset();
    tx_ready = 1'b1;
    exp_word(36'h3_1122_3344);
    exp_q.push_back(8'h3C);
    trace_data = 36'h3_1122_3344;
    trace_valid = 1'b1;
    tick();
    trace_valid = 1'b0;
    tick();
    tick();
    tick();
    check("t4_byte2", tx_data, 8'h22);
    send_con(8'h3C, waited, gap);
    check("t4_wait", waited, 3);
    check("t4_idle_gap", gap, 1'b1);
    drain(100, "t4");

    // Trap ends capture; later words neither captured nor counted
    do_reset();
    tx_ready = 1'b1;
    exp_q.push_back(8'hA4);
    exp_q.push_back(8'hCA);
    exp_q.push_back(8'hFE);
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'h0D);
    trace_data = 36'h4_CAFE_F00D;
    trace_valid = 1'b1;
    trap = 1'b1;
    tick();
    trap = 1'b0;
    for (int i = 0; i < 3; i++) begin
      trace_data = 36'h7_7777_0000 + 36'(i);
      tick();
    end
    trace_valid = 1'b0;
    check("t5_overflow", overflow_count, 16'd0);
    check("t5_done_early", done, 1'b0);
    for (int i = 0; i < 40; i++) begin
      if (done) break;
      tick();
    end
    check("t5_done", done, 1'b1);
    check("t5_queue_at_done", exp_q.size(), 0);
    check("t5_level", fifo_level, 5'd0);
    trace_valid = 1'b1;
    tick();
    trace_valid = 1'b0;
    check("t5_post_trap_ignored", fifo_level, 5'd0);
    check("t5_done_sticky", done, 1'b1);

    // Long stall mid-frame, then reset abandons it
    do_reset();
    tx_ready = 1'b0;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h01);
    trace_data = 36'h5_0102_0304;
    trace_valid = 1'b1;
    tick();
    trace_data = 36'h6_FFFF_FFFF;
    tick();
    trace_valid = 1'b0;
    tick();
    tick();
    check("t6_hold_byte0", tx_data, 8'hA5);
    tx_ready = 1'b1;
    tick();
    tick();
    tx_ready = 1'b0;
    check("t6_byte2", tx_data, 8'h02);
    repeat (10) tick();
    check("t6_stalled_data", tx_data, 8'h02);
    check("t6_stalled_valid", tx_valid, 1'b1);
    check("t6_level", fifo_level, 5'd1);
    check("t6_queue", exp_q.size(), 0);
    reset = 1'b1;
    tick();
    check("t6_rst_tx_valid", tx_valid, 1'b0);
    check("t6_rst_level", fifo_level, 5'd0);
    check("t6_rst_done", done, 1'b0);
    reset = 1'b0;
    tick();
    check("t6_after_rst_valid", tx_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
